// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, PC width,
// reset vector and the halt FSM state encoding.
package cpu_defs;

   localparam int          PC_W        = 32;
   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam logic [5:0]  OPC_SPECIAL = 6'h00;
   localparam logic [5:0]  FUNCT_BREAK = 6'h0D;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   // BREAK is SPECIAL/funct 0x0D; the 20-bit code field is don't-care.
   function automatic logic is_break(input logic [31:0] instr);
      return (instr[31:26] == OPC_SPECIAL) && (instr[5:0] == FUNCT_BREAK);
   endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. load captures a fetched word, bubble inserts a
// NOP with valid cleared (PC fields kept), otherwise the register holds.
module if_id_reg
   import cpu_defs::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            bubble,
   input  logic [31:0]     instr_in,
   input  logic [PC_W-1:0] pc_in,
   input  logic [PC_W-1:0] pc4_in,
   output logic [31:0]     instr,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc4,
   output logic            valid
);

   logic [31:0]     instr_d, instr_q;
   logic [PC_W-1:0] pc_d, pc_q;
   logic [PC_W-1:0] pc4_d, pc4_q;
   logic            valid_d, valid_q;

   // Next-value select: bubble wins over load; neither means hold.
   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (bubble) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (load) begin
         instr_d = instr_in;
         pc_d    = pc_in;
         pc4_d   = pc4_in;
         valid_d = 1'b1;
      end
   end

   // Register with synchronous reset to an empty slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign instr = instr_q;
   assign pc    = pc_q;
   assign pc4   = pc4_q;
   assign valid = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the
// RUN/HALTED fetch FSM that parks fetch after a BREAK.
//
//  state  | meaning
//  RUN    | fetching one word per cycle (unless stalled or redirected)
//  HALTED | BREAK was fetched; pc frozen, IF/ID fed bubbles until resume
module if_fetch_stage
   import cpu_defs::*;
#(
   parameter int          ROM_AW     = 5,
   parameter logic [31:0] RESET_PC_P = RESET_PC
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   input  logic              resume,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_instr,
   output logic [31:0]       if_id_instr,
   output logic [31:0]       if_id_pc,
   output logic [31:0]       if_id_pc4,
   output logic              if_id_valid,
   output logic              halted
);

   logic [PC_W-1:0] pc_d, pc_q;
   fetch_state_e    state_d, state_q;
   logic [PC_W-1:0] pc_plus4;
   logic            ld_fetch;
   logic            ld_bubble;

   assign pc_plus4 = pc_q + 32'd4;
   assign rom_addr = pc_q[ROM_AW+1:2];

   // Next PC / state / IF/ID control: redirect > stall > normal fetch.
   always_comb begin
      pc_d      = pc_q;
      state_d   = state_q;
      ld_fetch  = 1'b0;
      ld_bubble = 1'b0;
      if (redirect_valid) begin
         pc_d      = redirect_pc & ~32'h3;
         state_d   = RUN;
         ld_bubble = 1'b1;
      end else if (state_q == RUN) begin
         if (!stall) begin
            ld_fetch = 1'b1;
            pc_d     = pc_plus4;
            if (is_break(rom_instr)) begin
               state_d = HALTED;
            end
         end
      end else begin
         // The resume cycle itself still only bubbles; fetch restarts next cycle.
         if (resume) begin
            state_d = RUN;
         end
         if (!stall) begin
            ld_bubble = 1'b1;
         end
      end
   end

   // PC and fetch-state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC_P;
         state_q <= RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   assign halted = (state_q == HALTED);

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .reset    (reset),
      .load     (ld_fetch),
      .bubble   (ld_bubble),
      .instr_in (rom_instr),
      .pc_in    (pc_q),
      .pc4_in   (pc_plus4),
      .instr    (if_id_instr),
      .pc       (if_id_pc),
      .pc4      (if_id_pc4),
      .valid    (if_id_valid)
   );

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and drives the word address of the combinational instruction ROM, which returns the instruction in the same cycle.
- Registers instruction and PC into the IF/ID pipeline register consumed by decode.
- Handles stall, branch/jump redirect, and halts fetch after fetching a BREAK until the debug/control logic resumes it.

Parameters:
- ROM_AW, 5, ROM word-address width; rom_addr = pc[ROM_AW+1:2].
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit hold; PC and IF/ID keep their values.
- redirect_valid  input  1  taken branch/jump from a later stage.
- redirect_pc  input  32  target PC; bits [1:0] ignored (treated as 00).
- resume  input  1  single-cycle pulse that leaves HALTED.
- rom_addr  output  ROM_AW  combinational word address to the ROM.
- rom_instr  input  32  ROM data for rom_addr, same cycle.
- if_id_instr  output  32  registered instruction.
- if_id_pc  output  32  registered PC of if_id_instr.
- if_id_pc4  output  32  registered if_id_pc + 4.
- if_id_valid  output  1  IF/ID slot holds a real instruction.
- halted  output  1  fetch is halted on BREAK.

Behaviour:
- Reset, applied synchronously and overriding everything:
  - pc=RESET_PC, state=RUN.
  - if_id_instr=0 (NOP), if_id_pc=0, if_id_pc4=0, if_id_valid=0, halted=0.
- rom_addr = pc[ROM_AW+1:2] at all times. Higher PC bits do not affect addressing, so addresses wrap modulo 2^ROM_AW words.
- BREAK detect: rom_instr[31:26]==0 and rom_instr[5:0]==6'h0D; code field ignored.
- State RUN, priority redirect > stall > normal, evaluated per cycle:
  - redirect_valid: pc<=redirect_pc with [1:0]=00; IF/ID <= bubble (instr=0, valid=0, pc/pc4 unchanged). Applies even when stall=1.
  - stall (no redirect): pc and all IF/ID outputs hold.
  - normal, not BREAK: IF/ID <= {rom_instr, pc, pc+4, valid=1}; pc<=pc+4.
  - normal, BREAK: IF/ID captures the break exactly as a normal fetch (valid=1) and pc<=pc+4; state<=HALTED and halted=1 from the next cycle.
- State HALTED:
  - pc frozen at break_pc+4; IF/ID <= bubble every cycle unless stall=1, in which case IF/ID holds.
  - resume: state<=RUN, halted<=0; fetch from the frozen pc starts the following cycle. It is not fetched in the resume cycle itself.
  - redirect_valid: has priority over resume; pc<=target, state<=RUN, IF/ID bubble.
  - resume while in RUN: ignored.
- pc+4 overflow wraps modulo 2^32; no flag.
- One fetch per cycle; latency: ROM word at pc appears on if_id_* one clock after pc is presented.
- Reset asserted mid-halt or mid-stall: all state returns to reset values on that edge.

Decomposition:
- Shared package (cpu_defs) holds:
  - OPC_SPECIAL=6'h00, FUNCT_BREAK=6'h0D
  - NOP_INSTR=32'h00000000
  - PC_W=32, RESET_PC default
  - State encoding RUN=1'b0, HALTED=1'b1
- One sub-module, natural split: if_id_reg, the IF/ID register with load/hold/bubble controls.
- PC register, next-PC mux and halt FSM stay in the top module.

Test Plan:
1. Reset then free run with the test program (addr0=24010001, addr1=24020002, addr2=00221821) -> if_id_instr = 24010001, 24020002, 00221821 on cycles 1-3; if_id_pc = 0, 4, 8; if_id_pc4 = 4, 8, C; valid=1.
2. stall=1 for 2 cycles while pc=8 -> rom_addr=2 held; if_id_instr stays 24020002 and if_id_pc stays 4 for both cycles; resumes with 00221821 at pc 8 after stall drops.
3. redirect_valid=1 with redirect_pc=0x0000001E while stall=1 -> next cycle valid=0 with instr=0, pc=0x1C, rom_addr=7; following fetch has if_id_pc=0x1C.
4. BREAK 0000004D at addr 5 -> if_id_instr=0000004D, if_id_pc=0x14, valid=1; halted=1 next cycle; pc frozen 0x18; bubbles for 10 cycles; resume pulse -> if_id_pc=0x18 with instr 000C3043 two cycles later.
5. In HALTED, assert resume and redirect_pc=0x0 together -> state RUN, if_id bubble, then 24010001 fetched from pc 0.
6. reset asserted during HALTED and during stall -> all outputs return to reset values on the next edge; pc=0; halted=0; valid=0.
